// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one-cycle-latency reads to instruction memory and
// buffers the returned words, with their PCs, in a small FIFO for the decoder.
module fetch_unit #(
  parameter int          PC_W     = 12,
  parameter int          INSTR_W  = 16,
  parameter int          DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic                             i_stop,
  input  logic                             i_redirect,
  input  logic [PC_W-1:0]                  i_redirect_pc,
  output logic                             o_imem_req,
  output logic [PC_W-1:0]                  o_imem_addr,
  input  logic [INSTR_W-1:0]               i_imem_data,
  output logic                             o_valid,
  output logic [PC_W-1:0]                  o_pc,
  output logic [INSTR_W-1:0]               o_instr,
  input  logic                             i_ready,
  output logic [$clog2(DEPTH+1)-1:0]       o_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PC_W-1:0]    pc_q;
  logic [PC_W-1:0]    inflight_pc_q;
  logic               inflight_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];

  logic               pop;
  logic               push;
  logic [CNT_W:0]     occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_valid     = (count_q != '0);
  assign o_count     = count_q;
  assign o_imem_addr = pc_q;
  assign pop         = o_valid & i_ready;
  // A redirect or reset in the capture cycle discards the returning word.
  assign push        = inflight_q & ~i_redirect & ~i_reset;

  // NOTE: every variable gets a value before any condition, so no latch is inferred.
  always_comb begin
    occupancy  = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
    o_imem_req = ~i_reset & ~i_redirect & ~i_stop & (occupancy < (CNT_W + 1)'(DEPTH));
  end

  assign o_pc    = o_valid ? pc_mem[rd_ptr_q]    : '0;
  assign o_instr = o_valid ? instr_mem[rd_ptr_q] : '0;

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q          <= PC_W'(RESET_PC);
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      inflight_q <= o_imem_req;
      if (o_imem_req) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + PC_W'(1);
      end
      if (i_redirect) begin
        pc_q     <= i_redirect_pc;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // NOTE: queue storage has no reset; o_valid gates the outputs, so stale entries never escape.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= inflight_pc_q;
      instr_mem[wr_ptr_q] <= i_imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a cycle model with a scoreboard queue mirrors
// the fetch queue; hand sequences pin down latencies, a phase table covers the rest.
module tb_fetch_unit;

  localparam logic [11:0] RST_PC = 12'h000;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1, i_stop = 1'b0, i_redirect = 1'b0, i_ready = 1'b0;
  logic [11:0] i_redirect_pc = '0;
  logic [15:0] i_imem_data = '0;
  logic        o_imem_req, o_valid;
  logic [11:0] o_imem_addr, o_pc;
  logic [15:0] o_instr;
  logic [2:0]  o_count;

  fetch_unit dut (
    .i_clk(clk), .i_reset(i_reset), .i_stop(i_stop), .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc), .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_data(i_imem_data), .o_valid(o_valid), .o_pc(o_pc), .o_instr(o_instr),
    .i_ready(i_ready), .o_count(o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] pc;
    logic [15:0] instr;
  } sb_t;

  typedef struct {
    logic        rst, stop, redir, rdy;
    logic [11:0] rpc;
    int          n;
    int          exp_cnt;
  } vec_t;

  sb_t         sb[$];
  int          n_tests = 0, n_fail = 0;
  logic        model_known = 1'b0, infl = 1'b0;
  logic [11:0] model_pc = '0, infl_pc = '0;
  logic [15:0] mem_next = '0;
  logic        s_req, s_valid;
  logic [11:0] s_addr, s_pc;
  logic [15:0] s_instr;
  logic [2:0]  s_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, sample 1 ns later, compare with the model,
  // then advance the model across the coming rising edge.
  task automatic step(input logic rst, input logic stop, input logic redir,
                      input logic rdy, input logic [11:0] rpc);
    logic exp_valid, exp_req, exp_pop;
    @(negedge clk);
    i_reset = rst; i_stop = stop; i_redirect = redir; i_ready = rdy;
    i_redirect_pc = rpc; i_imem_data = mem_next;
    #1;
    s_req = o_imem_req; s_addr = o_imem_addr; s_valid = o_valid;
    s_pc = o_pc; s_instr = o_instr; s_count = o_count;
    exp_valid = (sb.size() != 0);
    exp_pop   = exp_valid & rdy;
    exp_req   = !rst && !redir && !stop &&
                ((sb.size() + int'(infl) - int'(exp_pop)) < 4);
    if (model_known) begin
      check("count", 32'(s_count), 32'(sb.size()));
      check("valid", 32'(s_valid), 32'(exp_valid));
      if (exp_valid) begin
        check("head_pc", 32'(s_pc), 32'(sb[0].pc));
        check("head_instr", 32'(s_instr), 32'(sb[0].instr));
      end else begin
        check("idle_pc", 32'(s_pc), 32'h0);
        check("idle_instr", 32'(s_instr), 32'h0);
      end
      check("req", 32'(s_req), 32'(exp_req));
      check("addr", 32'(s_addr), 32'(model_pc));
    end
    mem_next = s_req ? ({4'h0, s_addr} + 16'h0100) : 16'hDEAD;
    if (rst) begin
      sb.delete(); infl = 1'b0; model_pc = RST_PC; model_known = 1'b1;
    end else if (model_known) begin
      if (redir) begin
        sb.delete(); infl = 1'b0; model_pc = rpc;
      end else begin
        if (exp_pop) void'(sb.pop_front());
        if (infl) sb.push_back('{pc: infl_pc, instr: {4'h0, infl_pc} + 16'h0100});
        infl = exp_req;
        if (exp_req) begin
          infl_pc  = model_pc;
          model_pc = model_pc + 12'd1;
        end
      end
    end
  endtask

  initial begin
    vec_t tbl [18];
    int   nreq;

    tbl = '{
      '{rst:1, stop:0, redir:0, rdy:1, rpc:12'h000, n:2,  exp_cnt:0},
      '{rst:0, stop:0, redir:0, rdy:1, rpc:12'h000, n:10, exp_cnt:1},
      '{rst:0, stop:0, redir:0, rdy:0, rpc:12'h000, n:6,  exp_cnt:4},
      '{rst:0, stop:0, redir:0, rdy:1, rpc:12'h000, n:3,  exp_cnt:3},
      '{rst:0, stop:0, redir:1, rdy:1, rpc:12'h7F0, n:1,  exp_cnt:3},
      '{rst:0, stop:0, redir:0, rdy:1, rpc:12'h000, n:1,  exp_cnt:0},
      '{rst:0, stop:0, redir:0, rdy:1, rpc:12'h000, n:4,  exp_cnt:1},
      '{rst:0, stop:0, redir:1, rdy:1, rpc:12'hFFE, n:1,  exp_cnt:1},
      '{rst:0, stop:0, redir:0, rdy:1, rpc:12'h000, n:6,  exp_cnt:1},
      '{rst:0, stop:1, redir:0, rdy:1, rpc:12'h000, n:5,  exp_cnt:0},
      '{rst:0, stop:0, redir:0, rdy:1, rpc:12'h000, n:4,  exp_cnt:1},
      '{rst:0, stop:0, redir:0, rdy:0, rpc:12'h000, n:1,  exp_cnt:1},
      '{rst:1, stop:0, redir:0, rdy:0, rpc:12'h000, n:1,  exp_cnt:2},
      '{rst:0, stop:0, redir:0, rdy:1, rpc:12'h000, n:1,  exp_cnt:0},
      '{rst:0, stop:0, redir:0, rdy:1, rpc:12'h000, n:3,  exp_cnt:1},
      '{rst:0, stop:1, redir:1, rdy:1, rpc:12'h123, n:1,  exp_cnt:1},
      '{rst:0, stop:1, redir:0, rdy:1, rpc:12'h000, n:2,  exp_cnt:0},
      '{rst:0, stop:0, redir:0, rdy:1, rpc:12'h000, n:4,  exp_cnt:1}
    };

    // Reset, then free-running fetch: first valid head two cycles after first request.
    step(1, 0, 0, 1, 12'h0);
    step(1, 0, 0, 1, 12'h0);
    step(0, 0, 0, 1, 12'h0);
    check("s1_c0_req", 32'(s_req), 32'h1);
    check("s1_c0_addr", 32'(s_addr), 32'h000);
    check("s1_c0_valid", 32'(s_valid), 32'h0);
    step(0, 0, 0, 1, 12'h0);
    check("s1_c1_addr", 32'(s_addr), 32'h001);
    check("s1_c1_valid", 32'(s_valid), 32'h0);
    step(0, 0, 0, 1, 12'h0);
    check("s1_c2_valid", 32'(s_valid), 32'h1);
    check("s1_c2_pc", 32'(s_pc), 32'h000);
    check("s1_c2_instr", 32'(s_instr), 32'h0100);
    step(0, 0, 0, 1, 12'h0);
    check("s1_c3_pc", 32'(s_pc), 32'h001);

    // Stalled consumer from reset: exactly DEPTH requests, then in-order drain.
    step(1, 0, 0, 0, 12'h0);
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 12'h0);
      if (s_req) nreq++;
    end
    check("s2_nreq", 32'(nreq), 32'd4);
    check("s2_full", 32'(s_count), 32'd4);
    check("s2_noreq", 32'(s_req), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 12'h0);
      check("s2_pop_pc", 32'(s_pc), 32'(i));
    end

    // Redirect while three entries are queued and one request is inflight.
    step(1, 0, 0, 0, 12'h0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 12'h0);
    step(0, 0, 1, 1, 12'h7F0);
    check("s3_n_count", 32'(s_count), 32'd3);
    step(0, 0, 0, 1, 12'h0);
    check("s3_n1_valid", 32'(s_valid), 32'h0);
    check("s3_n1_count", 32'(s_count), 32'h0);
    check("s3_n1_addr", 32'(s_addr), 32'h7F0);
    check("s3_n1_req", 32'(s_req), 32'h1);
    step(0, 0, 0, 1, 12'h0);
    check("s3_n2_valid", 32'(s_valid), 32'h0);
    step(0, 0, 0, 1, 12'h0);
    check("s3_n3_valid", 32'(s_valid), 32'h1);
    check("s3_n3_pc", 32'(s_pc), 32'h7F0);
    check("s3_n3_instr", 32'(s_instr), 32'h08F0);

    // Stop with one request inflight: response captured, PC held, fetch resumes.
    step(1, 0, 0, 1, 12'h0);
    step(0, 0, 0, 1, 12'h0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 1, 12'h0);
      check("s4_stop_req", 32'(s_req), 32'h0);
      check("s4_stop_addr", 32'(s_addr), 32'h001);
    end
    step(0, 0, 0, 1, 12'h0);
    check("s4_resume_req", 32'(s_req), 32'h1);
    check("s4_resume_addr", 32'(s_addr), 32'h001);

    // Phase table; the scoreboard checks every cycle, the table pins phase-end counts.
    foreach (tbl[k]) begin
      for (int c = 0; c < tbl[k].n; c++)
        step(tbl[k].rst, tbl[k].stop, tbl[k].redir, tbl[k].rdy, tbl[k].rpc);
      check("tbl_count", 32'(s_count), 32'(tbl[k].exp_cnt));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 12: program counter and instruction-address width in bits.
REQ-002 Parameter INSTR_W, default 16: instruction word width in bits.
REQ-003 Parameter DEPTH, default 4: fetch-queue entries; legal range 2..16.
REQ-004 Parameter RESET_PC, default 0: PC loaded by reset.
REQ-005 Port i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 Port i_reset  in  1  reset, synchronous, active-high.
REQ-007 Port i_stop  in  1  fetch freeze: blocks new memory requests only.
REQ-008 Port i_redirect  in  1  branch/jump redirect strobe.
REQ-009 Port i_redirect_pc  in  PC_W  redirect target, sampled when i_redirect=1.
REQ-010 Port o_imem_req  out  1  instruction-memory read request this cycle.
REQ-011 Port o_imem_addr  out  PC_W  request address, always equal to current PC register.
REQ-012 Port i_imem_data  in  INSTR_W  read data; valid exactly one cycle after its request.
REQ-013 Port o_valid  out  1  queue head holds a valid instruction.
REQ-014 Port o_pc  out  PC_W  PC of queue head.
REQ-015 Port o_instr  out  INSTR_W  instruction of queue head.
REQ-016 Port i_ready  in  1  downstream accepts head; pop = o_valid & i_ready.
REQ-017 Port o_count  out  clog2(DEPTH+1)  occupied queue entries.

Function
REQ-018 Request condition SHALL be o_imem_req = ~i_reset & ~i_redirect & ~i_stop & (count + inflight - pop < DEPTH); combinational path from i_ready is permitted.
REQ-019 On request, PC SHALL advance by 1 modulo 2^PC_W; all-ones wraps to 0 with no flag.
REQ-020 A single inflight bit SHALL track the one outstanding request together with its PC; it is set on request and cleared the following cycle.
REQ-021 In the cycle after an unsquashed request, i_imem_data and its PC SHALL be written to the queue tail; there is no bypass, so o_valid rises the cycle after the write edge.
REQ-022 Minimum request-to-o_valid latency SHALL be 2 cycles.
REQ-023 Throughput SHALL be one instruction per cycle when i_ready=1 continuously and i_stop=0.
REQ-024 Push and pop in the same cycle SHALL leave o_count unchanged; FIFO order SHALL be preserved; the queue SHALL never overflow or underflow.
REQ-025 When o_valid=0, o_pc and o_instr SHALL be driven to 0.
REQ-026 Redirect in cycle N SHALL clear the queue, squash any inflight response returning in N+1, and load PC <= i_redirect_pc; o_valid=0 in N+1; first new request issues in N+1; the first redirected instruction is valid in N+3.
REQ-027 A pop in the redirect cycle SHALL still complete as a handshake; the cleared queue takes priority over any push in that cycle.
REQ-028 Priority SHALL be i_reset > i_redirect > i_stop.
REQ-029 i_stop SHALL NOT block pops or capture of an already-inflight response; PC SHALL hold while i_stop=1.

Reset
REQ-030 Reset values: PC=RESET_PC; queue empty; o_count=0; inflight=0; o_valid=0; o_imem_req=0; o_pc=0; o_instr=0.
REQ-031 Reset asserted mid-operation SHALL discard queue contents and the inflight response in the same edge; no push SHALL occur in the first cycle after reset.
REQ-032 First request SHALL issue in the first cycle after reset deasserts, with o_imem_addr=RESET_PC.

Verification
REQ-033 Reset, then i_ready=1, memory returns addr+0x100 -> o_imem_addr 0x000,0x001,...; o_valid first high in cycle 2 with o_pc=0x000, o_instr=0x0100; one instruction per cycle thereafter.
REQ-034 i_ready=0 from reset, DEPTH=4 -> exactly 4 requests; o_count=4; o_imem_req=0 afterwards; on i_ready=1, PCs 0x000..0x003 are popped in order.
REQ-035 Redirect to 0x7F0 while o_count=3 and a request is inflight -> next cycle o_count=0 and o_valid=0; squashed data is never seen; next valid head is o_pc=0x7F0 at N+3.
REQ-036 PC=0xFFE, run 3 instructions -> o_pc sequence 0xFFE, 0xFFF, 0x000.
REQ-037 i_stop=1 for 5 cycles while one request is inflight -> that response is queued, no new requests issue, PC holds, and fetch resumes from the held PC after release.
REQ-038 Reset asserted with o_count=2 -> next cycle o_valid=0, o_count=0, o_imem_addr=RESET_PC.
